// File: rtl/restador_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package restador_pkg;

  // Default operand/result width in bits.
  localparam int unsigned DEF_WIDTH = 8;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/restador_completo_1b.sv
// One-bit full subtractor: x - y - bi -> difference di, borrow-out bo.
module restador_completo_1b (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic di,
  output logic bo
);

  // Difference bit and borrow generated or propagated through this bit.
  always_comb begin
    di = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/restador_serial.sv
// LSB-first bit-serial subtractor d = a - b - bin with start/busy/done handshake.
module restador_serial
  import restador_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             load_c;
  logic             shift_c;
  logic             last_c;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             di_c;
  logic             bo_c;

  // Single full-subtractor cell working on the current LSBs and held borrow.
  restador_completo_1b u_cell (
    .x  (ra[0]),
    .y  (rb[0]),
    .bi (br),
    .di (di_c),
    .bo (bo_c)
  );

  // State register with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    state_nxt = state;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    load_c    = 1'b0;
    shift_c   = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = SHIFT;
          busy_nxt  = 1'b1;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (cnt == CNT_LAST) begin
          last_c    = 1'b1;
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          busy_nxt = 1'b1;
        end
      end
      DONE: begin
        // start is deliberately not looked at here; it is not queued.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand/result shift registers, borrow chain, bit counter and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (load_c) begin
      ra   <= a;
      rb   <= b;
      br   <= bin;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (shift_c) begin
      d  <= {di_c, d[WIDTH-1:1]};
      ra <= {1'b0, ra[WIDTH-1:1]};
      rb <= {1'b0, rb[WIDTH-1:1]};
      br <= bo_c;
      if (last_c) begin
        // Counter parks at its terminal value instead of wrapping.
        bout <= bo_c;
        ovf  <= br ^ bo_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_restador_serial.sv
// Directed self-checking bench for restador_serial (WIDTH=8).
module tb_restador_serial;

  localparam int W       = 8;
  localparam int TIMEOUT = 40;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;
  logic         busy;
  logic         done;

  int total;
  int bad;

  restador_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and follow it to done; inputs change on negedge.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       output int edges, output int busy_n, output int both_n);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1; busy_n = 0; both_n = 0;
    while (done !== 1'b1 && edges < TIMEOUT) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      edges++;
    end
    if (busy === 1'b1 && done === 1'b1) both_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({d, bout, ovf, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got d=%h bout=%b ovf=%b busy=%b done=%b, want all 0",
               d, bout, ovf, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_vec(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ibin, input logic [W-1:0] ed, input logic eb,
                          input logic eo, input logic chk_timing);
    int edges, busy_n, both_n;
    do_op(ia, ib, ibin, edges, busy_n, both_n);
    total++;
    if (d !== ed || bout !== eb || ovf !== eo) begin
      bad++;
      $display("FAIL %s_result: got d=%h bout=%b ovf=%b, want d=%h bout=%b ovf=%b",
               nm, d, bout, ovf, ed, eb, eo);
    end
    if (chk_timing) begin
      total++;
      if (edges !== W + 1) begin
        bad++;
        $display("FAIL %s_latency: got %0d edges, want %0d", nm, edges, W + 1);
      end
      total++;
      if (busy_n !== W || both_n !== 0) begin
        bad++;
        $display("FAIL %s_busy: got busy cycles=%0d overlap=%0d, want %0d and 0",
                 nm, busy_n, both_n, W);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || d !== ed || bout !== eb || ovf !== eo) begin
      bad++;
      $display("FAIL %s_hold: got done=%b d=%h bout=%b ovf=%b, want done=0 d=%h bout=%b ovf=%b",
               nm, done, d, bout, ovf, ed, eb, eo);
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    @(negedge clk);
    a = 8'h44; b = 8'h07; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done === 1'b1) begin
        dones++;
        total++;
        if (d !== 8'h3D || bout !== 1'b0 || ovf !== 1'b0) begin
          bad++;
          $display("FAIL ignore_start_result: got d=%h bout=%b ovf=%b, want d=3d bout=0 ovf=0",
                   d, bout, ovf);
        end
      end
      @(negedge clk);
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL ignore_start_dones: got %0d done pulses, want 1", dones);
    end
  endtask

  task automatic test_reset_abort();
    int dones, edges, busy_n, both_n;
    @(negedge clk);
    a = 8'h8F; b = 8'hA8; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy4: got busy=%b, want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({d, bout, ovf, busy, done} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: got d=%h bout=%b ovf=%b busy=%b done=%b, want all 0",
               d, bout, ovf, busy, done);
    end
    dones = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, want 0", dones);
    end
    do_op(8'h8F, 8'hA8, 1'b0, edges, busy_n, both_n);
    total++;
    if (d !== 8'hE7 || bout !== 1'b1 || ovf !== 1'b0 || edges !== W + 1) begin
      bad++;
      $display("FAIL abort_rerun: got d=%h bout=%b ovf=%b edges=%0d, want d=e7 bout=1 ovf=0 edges=%0d",
               d, bout, ovf, edges, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    a = 8'h16; b = 8'h02; bin = 1'b0; start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: got no done within %0d cycles, want a done", TIMEOUT);
    end
    @(negedge clk);
    n = 1;
    while (done !== 1'b1 && n < TIMEOUT) begin
      if (busy === 1'b1 && done === 1'b1) n = TIMEOUT;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    total++;
    if (n !== W + 2 || d !== 8'h14 || bout !== 1'b0) begin
      bad++;
      $display("FAIL b2b_period: got period=%0d d=%h bout=%b, want period=%0d d=14 bout=0",
               n, d, bout, W + 2);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_vec("sub_16_02", 8'h16, 8'h02, 1'b0, 8'h14, 1'b0, 1'b0, 1'b1);
    test_vec("sub_02_16", 8'h02, 8'h16, 1'b0, 8'hEC, 1'b1, 1'b0, 1'b1);
    test_vec("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    test_vec("sub_00_00_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    test_vec("sub_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
